// File: rtl/cpu_run_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_run_sequencer_if
//   Host command handshake for the CPU run sequencer.
//   cmd_valid  host -> sequencer  command offered
//   cmd_ready  sequencer -> host  sequencer can take a command this cycle
//   cmd_op     host -> sequencer  00 LOAD, 01 RUN, 10 STEP, 11 PTR_CLR
//   cmd_data   host -> sequencer  instruction word carried by LOAD
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface cpu_run_sequencer_if #(
  parameter int INSTR_W = 2
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [INSTR_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/cpu_run_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_run_sequencer
//   Run controller for the 2-bit accumulator CPU core. Loads the core's
//   instruction memory from host LOAD commands, then sequences execution by
//   driving the core's reset and clock-enable: a full program pass (RUN) or a
//   single instruction (STEP). The core accumulator is captured into
//   result_data when execution stops.
//
// Ports
//   clk, reset     clock (rising edge), synchronous active-high reset
//   cmd            host command handshake (slave side)
//   halt           abort request, honoured only while in RUN
//   imem_we/addr/wdata   instruction memory write port towards the core
//   cpu_reset      core reset (clears pc and register_A at the edge)
//   cpu_en         core clock-enable
//   cpu_data       core output_data (accumulator)
//   result_data    captured accumulator, result_valid pulses on update
//   busy           controller not idle
//   cycle_count    enabled core cycles since the last CLEAR (saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_run_sequencer #(
  parameter int IMEM_DEPTH = 4,
  parameter int PC_W       = 2,
  parameter int INSTR_W    = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_run_sequencer_if.slave   cmd,
  input  logic                 halt,
  output logic                 imem_we,
  output logic [PC_W-1:0]      imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  input  logic [1:0]           cpu_data,
  output logic [1:0]           result_data,
  output logic                 result_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STEP,
    S_CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_RUN     = 2'b01,
    OP_STEP    = 2'b10,
    OP_PTR_CLR = 2'b11
  } op_t;

  localparam logic [PC_W-1:0] LAST_IDX = PC_W'(IMEM_DEPTH - 1);

  state_t          state;
  state_t          next_state;
  op_t             op;
  logic            accept;
  logic            run_last;
  logic [PC_W-1:0] load_ptr;
  logic [PC_W-1:0] run_cnt;

  // Handshake and status decode straight from state, so a new command can be
  // taken in the very cycle result_valid is high.
  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

  assign accept   = cmd.cmd_valid && cmd.cmd_ready;
  assign op       = op_t'(cmd.cmd_op);
  assign run_last = (run_cnt == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_RUN:  next_state = S_CLEAR;
            OP_STEP: next_state = S_STEP;
            default: next_state = S_IDLE;
          endcase
        end
      end
      S_CLEAR:   next_state = S_RUN;
      // A halt on the final RUN cycle lands in CAPTURE exactly like completion.
      S_RUN:     if (halt || run_last) next_state = S_CAPTURE;
      S_STEP:    next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Registered outputs are computed from next_state so they are valid for the
  // whole cycle spent in the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_ptr     <= '0;
      cpu_reset    <= 1'b1;
      cpu_en       <= 1'b0;
      run_cnt      <= '0;
      cycle_count  <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept && (op == OP_LOAD)) begin
        imem_we    <= 1'b1;
        imem_addr  <= load_ptr;
        imem_wdata <= cmd.cmd_data;
        load_ptr   <= (load_ptr == LAST_IDX) ? '0 : load_ptr + 1'b1;
      end else if (accept && (op == OP_PTR_CLR)) begin
        load_ptr <= '0;
      end

      cpu_reset <= (next_state == S_CLEAR);
      cpu_en    <= (next_state == S_RUN) || (next_state == S_STEP);

      // run_cnt indexes the current RUN cycle; it is zero on entry.
      if (state == S_RUN) begin
        run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end

      // STEPs accumulate; only the CLEAR of a RUN restarts the count.
      if (next_state == S_CLEAR) begin
        cycle_count <= '0;
      end else if (cpu_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end

      result_valid <= (state == S_CAPTURE);
      if (state == S_CAPTURE) begin
        result_data <= cpu_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
`timescale 1ns/1ps

module tb_cpu_run_sequencer;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_PTR_CLR = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       halt;
  logic       imem_we;
  logic [1:0] imem_addr;
  logic [1:0] imem_wdata;
  logic       cpu_reset;
  logic       cpu_en;
  logic [1:0] cpu_data;
  logic [1:0] result_data;
  logic       result_valid;
  logic       busy;
  logic [7:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  cpu_run_sequencer_if #(.INSTR_W(2)) cmd_if ();

  cpu_run_sequencer #(
    .IMEM_DEPTH(4), .PC_W(2), .INSTR_W(2), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if),
    .halt         (halt),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .cpu_en       (cpu_en),
    .cpu_data     (cpu_data),
    .result_data  (result_data),
    .result_valid (result_valid),
    .busy         (busy),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the accumulator core driven by the sequencer.
  logic [1:0] core_mem [4];
  logic [1:0] core_pc;
  logic [1:0] core_a;
  assign cpu_data = core_a;

  always @(posedge clk) begin
    if (imem_we) core_mem[imem_addr] <= imem_wdata;
    if (cpu_reset) begin
      core_pc <= 2'd0;
      core_a  <= 2'd0;
    end else if (cpu_en) begin
      if (core_mem[core_pc][1]) core_a <= core_a + {1'b0, core_mem[core_pc][0]};
      else                      core_a <= {1'b0, core_mem[core_pc][0]};
      core_pc <= core_pc + 2'd1;
    end
  end

  // Reference model: program image, load pointer, core pc/accumulator, count.
  int prog [4];
  int m_ptr, m_pc, m_acc, m_count;

  function automatic void model_exec(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = prog[m_pc];
      if (w >= 2) m_acc = (m_acc + (w % 2)) % 4;
      else        m_acc = w % 2;
      m_pc = (m_pc + 1) % 4;
    end
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_pc = 0; m_acc = 0; m_count = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (cmd_if.cmd_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_timeout cmd_ready=%b expected 1", name, cmd_if.cmd_ready);
    end
    n_cmp++;
  endtask

  // Leaves cmd_valid high so consecutive calls produce back-to-back LOADs.
  task automatic load_word(input logic [1:0] w);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = w;
    tick();
    if (imem_we !== 1'b1 || imem_addr !== 2'(m_ptr) || imem_wdata !== w) begin
      n_err++;
      $display("FAIL load_write we=%b addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
               imem_we, imem_addr, imem_wdata, m_ptr, w);
    end
    n_cmp++;
    prog[m_ptr] = int'(w);
    m_ptr = (m_ptr + 1) % 4;
  endtask

  task automatic load_prog(input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d);
    load_word(a); load_word(b); load_word(c); load_word(d);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic ptr_clr();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_PTR_CLR;
    tick();
    cmd_if.cmd_valid = 1'b0;
    if (imem_we !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ptr_clr we=%b busy=%b expected 0 0", imem_we, busy);
    end
    n_cmp++;
    m_ptr = 0;
  endtask

  // Issues RUN or STEP and checks latency, enabled cycles, result and count.
  // halt_at: RUN cycle (1-based) carrying halt, 0 for none; noise drives halt
  // throughout a STEP, where it must be ignored.
  task automatic run_op(input logic [1:0] op, input int halt_at, input bit noise,
                        input string name);
    int n, en, n_exec, exp_lat;
    if (op == OP_RUN) begin
      m_pc = 0; m_acc = 0;
      n_exec  = (halt_at > 0 && halt_at < 4) ? halt_at : 4;
      m_count = n_exec;
      exp_lat = 3 + n_exec;
    end else begin
      n_exec  = 1;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      exp_lat = 3;
    end
    model_exec(n_exec);

    wait_ready(name);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    tick();
    cmd_if.cmd_valid = 1'b0;
    n  = 1;
    en = 0;
    if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy ready=%b busy=%b expected 0 1", name, cmd_if.cmd_ready, busy);
    end
    n_cmp++;
    if (op == OP_RUN) begin
      if (cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s_clear cpu_reset=%b cpu_en=%b expected 1 0", name, cpu_reset, cpu_en);
      end
      n_cmp++;
    end
    while (result_valid !== 1'b1 && n < 40) begin
      if (cpu_en === 1'b1) en++;
      if (op == OP_RUN) halt = (halt_at > 0) && (n == 1 + halt_at);
      else              halt = noise;
      tick();
      n++;
    end
    halt = 1'b0;

    if (n != exp_lat) begin
      n_err++;
      $display("FAIL %s_latency got %0d expected %0d", name, n, exp_lat);
    end
    n_cmp++;
    if (en != n_exec) begin
      n_err++;
      $display("FAIL %s_en_cycles got %0d expected %0d", name, en, n_exec);
    end
    n_cmp++;
    if (result_data !== 2'(m_acc)) begin
      n_err++;
      $display("FAIL %s_result got %0d expected %0d", name, result_data, m_acc);
    end
    n_cmp++;
    if (cycle_count !== 8'(m_count)) begin
      n_err++;
      $display("FAIL %s_cycle_count got %0d expected %0d", name, cycle_count, m_count);
    end
    n_cmp++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_at_result got %b expected 1", name, cmd_if.cmd_ready);
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    halt  = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_reset !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d cpu_reset=%b expected 1", i, cpu_reset);
      end
      n_cmp++;
    end
    reset = 1'b0;
    if (cpu_reset !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_edge cpu_reset=%b expected 1", cpu_reset);
    end
    n_cmp++;
    tick();
    if (cpu_reset !== 1'b0 || cpu_en !== 1'b0 || imem_we !== 1'b0 || result_valid !== 1'b0 ||
        result_data !== 2'd0 || cycle_count !== 8'd0 || busy !== 1'b0 ||
        imem_addr !== 2'd0 || imem_wdata !== 2'd0 || cmd_if.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle rst=%b en=%b we=%b rv=%b rd=%0d cnt=%0d busy=%b addr=%0d wd=%0d rdy=%b expected all 0, rdy 1",
               cpu_reset, cpu_en, imem_we, result_valid, result_data, cycle_count, busy,
               imem_addr, imem_wdata, cmd_if.cmd_ready);
    end
    n_cmp++;
    model_reset();
  endtask

  task automatic test_step();
    load_prog(2'b01, 2'b11, 2'b00, 2'b00);
    run_op(OP_STEP, 0, 1'b0, "step1");
    run_op(OP_STEP, 0, 1'b1, "step2");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) run_op(OP_STEP, 0, 1'(i % 2), "sat_step");
  endtask

  task automatic test_load_run();
    load_prog(2'b01, 2'b11, 2'b11, 2'b10);
    run_op(OP_RUN, 0, 1'b0, "run_basic");
  endtask

  task automatic test_wrap();
    load_word(2'b01); load_word(2'b11); load_word(2'b11); load_word(2'b11);
    load_word(2'b00);
    cmd_if.cmd_valid = 1'b0;
    ptr_clr();
    load_prog(2'b01, 2'b11, 2'b11, 2'b11);
    run_op(OP_RUN, 0, 1'b0, "run_wrap");
  endtask

  task automatic test_halt();
    run_op(OP_RUN, 2, 1'b0, "run_halt2");
    tick();
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL result_valid_pulse got %b expected 0", result_valid);
    end
    n_cmp++;
    run_op(OP_RUN, 4, 1'b0, "run_halt_last");
    run_op(OP_RUN, 5, 1'b0, "run_halt_capture");
  endtask

  task automatic test_reset_mid_run();
    wait_ready("mid_reset");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_RUN;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || cpu_en !== 1'b0 || cpu_reset !== 1'b1 ||
        result_valid !== 1'b0 || cycle_count !== 8'd0) begin
      n_err++;
      $display("FAIL mid_reset rdy=%b busy=%b en=%b rst=%b rv=%b cnt=%0d expected 1 0 0 1 0 0",
               cmd_if.cmd_ready, busy, cpu_en, cpu_reset, result_valid, cycle_count);
    end
    n_cmp++;
    reset = 1'b0;
    tick();
    if (result_valid !== 1'b0 || cpu_reset !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_after rv=%b rst=%b expected 0 0", result_valid, cpu_reset);
    end
    n_cmp++;
    model_reset();
    load_prog(2'b01, 2'b11, 2'b11, 2'b10);
    run_op(OP_RUN, 0, 1'b0, "post_reset_run");
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int k;
      if ($urandom_range(0, 2) == 0) ptr_clr();
      k = int'($urandom_range(0, 5));
      for (int j = 0; j < k; j++) load_word(2'($urandom_range(0, 3)));
      cmd_if.cmd_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) run_op(OP_RUN, int'($urandom_range(0, 5)), 1'b0, "rand_run");
      else                           run_op(OP_STEP, 0, 1'($urandom_range(0, 1)), "rand_step");
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) prog[i] = 0;
    test_reset();
    test_step();
    test_saturation();
    test_load_run();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/cpu_run_sequencer.md
# cpu_run_sequencer

Run controller for the 2-bit accumulator CPU core. Loads the core's 4-entry instruction memory from a host command stream, then sequences execution by driving the core's reset and clock-enable: a full run of one program pass, or single steps. Captures the core's `output_data` into a result register when execution stops. Sits between the host/testbench command port and the CPU core. The core holds `pc` and `register_A` whenever `cpu_en` is low.

## Interface
- `IMEM_DEPTH`, 4, instruction memory entries; also the number of enabled cycles in a RUN
- `PC_W`, 2, instruction address width
- `INSTR_W`, 2, instruction width: bit1 is the opcode (0 LOAD, 1 ADD), bit0 is the data
- `CNT_W`, 8, width of `cycle_count`

- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — high exactly when in IDLE
- `cmd_op` in 2 — 00 LOAD, 01 RUN, 10 STEP, 11 PTR_CLR
- `cmd_data` in INSTR_W — instruction word for LOAD
- `halt` in 1 — abort request, honoured only in RUN
- `imem_we` out 1 — instruction memory write strobe
- `imem_addr` out PC_W — write address
- `imem_wdata` out INSTR_W — write data
- `cpu_reset` out 1 — core reset; clears `pc` and `register_A` at the edge
- `cpu_en` out 1 — core clock-enable
- `cpu_data` in 2 — core `output_data`
- `result_data` out 2 — captured accumulator
- `result_valid` out 1 — one-cycle pulse when `result_data` updates
- `busy` out 1 — state ≠ IDLE
- `cycle_count` out CNT_W — enabled core cycles since the last CLEAR

## Operation
- FSM states: IDLE, CLEAR, RUN, STEP, CAPTURE. All outputs are registered except `cmd_ready` and `busy`, which decode directly from state.
- Reset values:
  - state IDLE
  - `cpu_reset` = 1 (core is held through controller reset; drops on the first edge after `reset` falls)
  - `cpu_en`, `imem_we`, `result_valid` = 0
  - `imem_addr`, `imem_wdata`, `result_data`, `cycle_count`, load pointer = 0
- A command is accepted when `cmd_valid` and `cmd_ready` are both high.
- LOAD:
  - Next cycle: `imem_we` = 1, `imem_addr` = load pointer, `imem_wdata` = `cmd_data`.
  - The pointer increments and wraps from IMEM_DEPTH-1 to 0.
  - State stays IDLE, so back-to-back LOADs write on consecutive cycles.
- PTR_CLR: load pointer becomes 0; state stays IDLE.
- RUN:
  - IDLE → CLEAR (`cpu_reset` = 1, `cycle_count` cleared) → RUN.
  - RUN holds `cpu_en` = 1 for IMEM_DEPTH cycles → CAPTURE.
- STEP: IDLE → STEP (`cpu_en` = 1 for one cycle, no core reset) → CAPTURE.
- CAPTURE:
  - `cpu_en` = 0.
  - At the closing edge: `result_data` ← `cpu_data`, `result_valid` ← 1, state → IDLE.
- `halt` = 1 at an edge in RUN:
  - Next state is CAPTURE.
  - `cpu_en` is low from the next cycle.
  - A halt coinciding with the final RUN cycle behaves the same as normal completion.
  - `halt` is ignored in all other states.
- `cycle_count` increments on every cycle with `cpu_en` = 1 and saturates at 2^CNT_W−1. STEPs accumulate across commands until the next RUN clears it.
- `reset` mid-operation:
  - All registers return to reset values on that edge; in-flight LOAD writes and captures are dropped.
  - Instruction memory contents are untouched (they are owned by the core).
- Arithmetic: the core accumulator wraps modulo 4; the controller passes `cpu_data` through unchanged.

## Timing
- LOAD accepted at cycle T: write strobe at T+1.
- RUN accepted at T:
  - T+1 CLEAR
  - T+2…T+1+IMEM_DEPTH RUN
  - T+2+IMEM_DEPTH CAPTURE
  - T+3+IMEM_DEPTH `result_valid` = 1 and `cmd_ready` = 1
  - Default depth gives result at T+7.
- STEP accepted at T: T+1 STEP, T+2 CAPTURE, T+3 `result_valid`.
- `halt` seen at RUN cycle k: CAPTURE at k+1, `result_valid` at k+2, `cycle_count` = number of RUN cycles completed.
- `cmd_ready` is low from T+1 until the cycle `result_valid` rises. A command may be accepted in that same cycle.

## Test plan
- Reset with `reset` held 3 cycles: `cpu_reset` = 1 throughout and for the release edge; then IDLE, `cmd_ready` = 1, all other outputs 0.
- LOAD 01, 11, 11, 10 back-to-back, then RUN: writes at addresses 0–3 on consecutive cycles; `result_valid` 7 cycles after the RUN accept; `result_data` = 3; `cycle_count` = 4.
- LOAD 01, 11, 11, 11 (fifth LOAD 00 wraps to address 0; follow with PTR_CLR and a reload of the same four words), then RUN: `result_data` = 0 (accumulator wraps modulo 4).
- Program 01, 11, 00, 00; STEP twice: results 1, then 2; `cycle_count` = 2; each `result_valid` arrives 3 cycles after its accept.
- Program 01, 11, 11, 11; RUN with `halt` pulsed in the second RUN cycle: `cpu_en` high for exactly 2 cycles; `result_data` = 2; `cycle_count` = 2.
- Assert `reset` during RUN cycle 3: next cycle IDLE, `cpu_en` = 0, `cpu_reset` = 1, no `result_valid`; a following RUN produces the normal result.
